// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Opcode field positions, nextctrl encodings and FSM states.
package fetch_pkg;

    localparam int PC_W_DEF   = 8;
    localparam int INST_W_DEF = 8;

    localparam int OP1_HI  = 7;
    localparam int OP1_LO  = 5;
    localparam int OP2_BIT = 4;
    localparam int OPND_HI = 3;
    localparam int OPND_LO = 0;

    localparam logic [1:0] NC_NONE    = 2'b00;
    localparam logic [1:0] NC_OFFSET  = 2'b01;
    localparam logic [1:0] NC_TARGET  = 2'b10;
    localparam logic [1:0] NC_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        WAIT_OP,
        DECODE,
        FETCH_EXT,
        WAIT_EXT,
        ISSUE
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory read bus: one request, one-cycle ack pulse.
// Master is the fetch unit, slave is the memory.
interface inst_fetch_if import fetch_pkg::*; #(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
) ();

    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC selection applied on the issue handshake.
// Priority: jr, then jal to target byte, then taken beq.
module pc_next_sel import fetch_pkg::*; #(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   ra_value,
    input  logic [INST_W-1:0] ext_byte,
    input  logic [3:0]        inst_opnd,
    input  logic              jrctrl,
    input  logic              jctrl,
    input  logic              is_target,
    input  logic              beqctrl,
    input  logic              br_taken,
    output logic [PC_W-1:0]   pc_new
);

    logic [PC_W-1:0] offset;

    assign offset = PC_W'($signed(inst_opnd));

    always_comb begin
        pc_new = pc;
        if (jrctrl) begin
            pc_new = ra_value;
        end else if (jctrl && is_target) begin
            pc_new = PC_W'(ext_byte);
        end else if (beqctrl && br_taken) begin
            pc_new = pc + offset;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch FSM: fetches opcode and optional extension
// byte, presents a stable bundle and redirects pc on handshake.
module inst_fetch import fetch_pkg::*; #(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_if.master      imem,
    output logic [2:0]        inst1,
    output logic              inst2,
    output logic [3:0]        inst_opnd,
    output logic [INST_W-1:0] ext_byte,
    input  logic [1:0]        nextctrl,
    input  logic              jctrl,
    input  logic              jrctrl,
    input  logic              beqctrl,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   ra_value,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [PC_W-1:0]   ret_addr,
    output logic              illegal
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic [INST_W-1:0] ext_q, ext_d;
    logic              tgt_q, tgt_d;
    logic [PC_W-1:0]   ret_q, ret_d;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_sel;

    assign pc_inc = pc_q + PC_W'(1);

    pc_next_sel #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_pc_next_sel (
        .pc        (pc_q),
        .ra_value  (ra_value),
        .ext_byte  (ext_q),
        .inst_opnd (ir_q[OPND_HI:OPND_LO]),
        .jrctrl    (jrctrl),
        .jctrl     (jctrl),
        .is_target (tgt_q),
        .beqctrl   (beqctrl),
        .br_taken  (br_taken),
        .pc_new    (pc_sel)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ext_d   = ext_q;
        tgt_d   = tgt_q;
        ret_d   = ret_q;
        unique case (state_q)
            FETCH: state_d = WAIT_OP;
            WAIT_OP: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_data;
                    ext_d   = '0;
                    tgt_d   = 1'b0;
                    pc_d    = pc_inc;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // illegal falls through as a single-byte instruction
                if (nextctrl == NC_OFFSET || nextctrl == NC_TARGET) begin
                    tgt_d   = (nextctrl == NC_TARGET);
                    state_d = FETCH_EXT;
                end else begin
                    ret_d   = pc_q;
                    state_d = ISSUE;
                end
            end
            FETCH_EXT: state_d = WAIT_EXT;
            WAIT_EXT: begin
                if (imem.imem_ack) begin
                    ext_d   = imem.imem_data;
                    pc_d    = pc_inc;
                    ret_d   = pc_inc;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (inst_ready) begin
                    pc_d    = pc_sel;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            ext_q   <= '0;
            tgt_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ext_q   <= ext_d;
            tgt_q   <= tgt_d;
            ret_q   <= ret_d;
        end
    end

    assign imem.imem_req  = !rst
        && (state_q == FETCH || state_q == FETCH_EXT);
    assign imem.imem_addr = pc_q;

    assign inst1      = ir_q[OP1_HI:OP1_LO];
    assign inst2      = ir_q[OP2_BIT];
    assign inst_opnd  = ir_q[OPND_HI:OPND_LO];
    assign ext_byte   = ext_q;
    assign ret_addr   = ret_q;
    assign inst_valid = !rst && (state_q == ISSUE);
    assign illegal    = !rst && (state_q == DECODE)
        && (nextctrl == NC_ILLEGAL);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory responder plus queues of
// expected fetch addresses and issued bundles.
module tb_inst_fetch;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_if #(.PC_W(8), .INST_W(8)) bus ();

    logic [2:0] inst1;
    logic       inst2;
    logic [3:0] inst_opnd;
    logic [7:0] ext_byte;
    logic [7:0] ret_addr;
    logic [7:0] ra_value;
    logic [1:0] nextctrl;
    logic       jctrl, jrctrl, beqctrl, br_taken;
    logic       inst_valid, inst_ready, illegal;

    inst_fetch #(.PC_W(8), .INST_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (bus.master),
        .inst1      (inst1),
        .inst2      (inst2),
        .inst_opnd  (inst_opnd),
        .ext_byte   (ext_byte),
        .nextctrl   (nextctrl),
        .jctrl      (jctrl),
        .jrctrl     (jrctrl),
        .beqctrl    (beqctrl),
        .br_taken   (br_taken),
        .ra_value   (ra_value),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .ret_addr   (ret_addr),
        .illegal    (illegal)
    );

    typedef struct {
        logic [2:0] i1;
        logic       i2;
        logic [3:0] opnd;
        logic [7:0] ext;
        logic [7:0] ret;
    } bun_t;

    logic [7:0] mem [256];
    logic [7:0] exp_addr [$];
    bun_t       exp_bun [$];
    int         checks = 0;
    int         errors = 0;
    bit         pend = 1'b0;
    logic [7:0] pend_addr;
    int         ill_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_bun(input string tag, input bun_t e);
        chk({tag, ".inst1"}, 32'(inst1), 32'(e.i1));
        chk({tag, ".inst2"}, 32'(inst2), 32'(e.i2));
        chk({tag, ".opnd"}, 32'(inst_opnd), 32'(e.opnd));
        chk({tag, ".ext_byte"}, 32'(ext_byte), 32'(e.ext));
        chk({tag, ".ret_addr"}, 32'(ret_addr), 32'(e.ret));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // memory responder: ack exactly one cycle after a sampled request
    task automatic obs();
        bus.imem_ack = 1'b0;
        if (pend) begin
            bus.imem_ack  = 1'b1;
            bus.imem_data = mem[pend_addr];
            pend = 1'b0;
        end
        if (bus.imem_req === 1'b1) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL fetch_unexpected: observed %0h expected none",
                       bus.imem_addr);
            end else begin
                chk("fetch_addr", 32'(bus.imem_addr),
                    32'(exp_addr.pop_front()));
            end
            pend = 1'b1;
            pend_addr = bus.imem_addr;
        end
        if (illegal === 1'b1) ill_cnt++;
    endtask

    task automatic run_instr(
        input string      tag,
        input logic [7:0] pc,
        input logic [1:0] nc,
        input logic       j, jr, beq, tk,
        input logic [7:0] ra,
        input int         stall,
        input logic [2:0] i1,
        input logic       i2,
        input logic [3:0] op,
        input logic [7:0] ext,
        input logic [7:0] ret
    );
        bun_t e;
        int n;
        int lat;
        logic [7:0] pc1;
        lat = (nc == NC_OFFSET || nc == NC_TARGET) ? 5 : 3;
        pc1 = pc + 8'd1;
        exp_addr.push_back(pc);
        if (lat == 5) exp_addr.push_back(pc1);
        e.i1 = i1;
        e.i2 = i2;
        e.opnd = op;
        e.ext = ext;
        e.ret = ret;
        exp_bun.push_back(e);
        nextctrl = nc;
        jctrl = j;
        jrctrl = jr;
        beqctrl = beq;
        br_taken = tk;
        ra_value = ra;
        inst_ready = (stall == 0);
        ill_cnt = 0;
        n = 0;
        obs();
        while (inst_valid !== 1'b1 && n < 20) begin
            adv();
            obs();
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(lat));
        if (inst_valid === 1'b1) begin
            e = exp_bun.pop_front();
            chk_bun(tag, e);
            for (int s = 0; s < stall; s++) begin
                adv();
                obs();
                chk({tag, ".hold_valid"}, 32'(inst_valid), 32'd1);
                chk_bun({tag, ".hold"}, e);
            end
            inst_ready = 1'b1;
            adv();
            inst_ready = 1'b0;
        end
        chk({tag, ".illegal"}, 32'(ill_cnt),
            (nc == NC_ILLEGAL) ? 32'd1 : 32'd0);
    endtask

    task automatic expect_fetch(input logic [7:0] a);
        int n;
        exp_addr.push_back(a);
        n = 0;
        obs();
        while (exp_addr.size() > 0 && n < 10) begin
            adv();
            obs();
            n++;
        end
        chk("fetch_done", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".imem_req"}, 32'(bus.imem_req), 32'd0);
        chk({tag, ".inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, ".illegal"}, 32'(illegal), 32'd0);
        chk({tag, ".ret_addr"}, 32'(ret_addr), 32'd0);
        chk({tag, ".ext_byte"}, 32'(ext_byte), 32'd0);
        chk({tag, ".inst1"}, 32'(inst1), 32'd0);
        chk({tag, ".opnd"}, 32'(inst_opnd), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'h00;
        nextctrl   = NC_NONE;
        jctrl      = 1'b0;
        jrctrl     = 1'b0;
        beqctrl    = 1'b0;
        br_taken   = 1'b0;
        ra_value   = 8'h33;
        inst_ready = 1'b0;

        rst = 1'b1;
        repeat (3) adv();
        chk_reset_state("reset");
        rst = 1'b0;
        #1;

        mem[8'h00] = 8'h20;
        mem[8'h01] = 8'h6E;
        mem[8'h02] = 8'h5F;
        run_instr("add0", 8'h00, NC_NONE, 0, 0, 0, 0, 8'h33, 0,
                  3'b001, 1'b0, 4'h0, 8'h00, 8'h01);
        run_instr("beq_tk", 8'h01, NC_NONE, 0, 0, 1, 1, 8'h33, 0,
                  3'b011, 1'b0, 4'hE, 8'h00, 8'h02);
        run_instr("add0b", 8'h00, NC_NONE, 0, 0, 0, 0, 8'h33, 0,
                  3'b001, 1'b0, 4'h0, 8'h00, 8'h01);
        run_instr("beq_nt", 8'h01, NC_NONE, 0, 0, 1, 0, 8'h33, 0,
                  3'b011, 1'b0, 4'hE, 8'h00, 8'h02);
        run_instr("jr_prio", 8'h02, NC_NONE, 0, 1, 1, 1, 8'h00, 0,
                  3'b010, 1'b1, 4'hF, 8'h00, 8'h03);

        mem[8'h00] = 8'h80;
        mem[8'h01] = 8'h05;
        mem[8'h02] = 8'hF0;
        mem[8'h03] = 8'hE0;
        mem[8'h04] = 8'h10;
        mem[8'h10] = 8'hE0;
        mem[8'h11] = 8'h40;
        mem[8'h40] = 8'hE0;
        mem[8'h41] = 8'hFF;
        mem[8'hFF] = 8'h20;
        run_instr("lw", 8'h00, NC_OFFSET, 0, 0, 0, 0, 8'h33, 0,
                  3'b100, 1'b0, 4'h0, 8'h05, 8'h02);
        run_instr("illegal", 8'h02, NC_ILLEGAL, 1, 0, 0, 0, 8'h33, 0,
                  3'b111, 1'b1, 4'h0, 8'h00, 8'h03);
        run_instr("jal3", 8'h03, NC_TARGET, 1, 0, 0, 0, 8'h33, 0,
                  3'b111, 1'b0, 4'h0, 8'h10, 8'h05);
        run_instr("jal10", 8'h10, NC_TARGET, 1, 0, 0, 0, 8'h33, 0,
                  3'b111, 1'b0, 4'h0, 8'h40, 8'h12);
        run_instr("jal40", 8'h40, NC_TARGET, 1, 0, 0, 0, 8'h33, 0,
                  3'b111, 1'b0, 4'h0, 8'hFF, 8'h42);
        run_instr("wrap_bp", 8'hFF, NC_NONE, 0, 0, 0, 0, 8'h33, 4,
                  3'b001, 1'b0, 4'h0, 8'h00, 8'h00);

        // abandon a two-byte fetch while waiting for its extension
        jctrl = 1'b0;
        exp_addr.push_back(8'h00);
        exp_addr.push_back(8'h01);
        nextctrl = NC_OFFSET;
        obs();
        repeat (4) begin
            adv();
            obs();
        end
        rst = 1'b1;
        adv();
        obs();
        chk_reset_state("mid_reset");
        bus.imem_ack = 1'b1;
        bus.imem_data = 8'hAA;
        adv();
        bus.imem_ack = 1'b0;
        chk_reset_state("reset_ack");
        rst = 1'b0;
        #1;
        mem[8'h00] = 8'h20;
        run_instr("post_rst", 8'h00, NC_NONE, 0, 0, 0, 0, 8'h33, 0,
                  3'b001, 1'b0, 4'h0, 8'h00, 8'h01);
        expect_fetch(8'h01);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and instruction-memory address width.
REQ-002 SHALL have parameter INST_W, default 8, meaning instruction and extension-byte width.
REQ-003 SHALL have one clock and one reset, with the reset synchronous and active-high; the ports are listed below.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  PC_W  read address.
- imem_ack  in  1  read data valid; one-cycle pulse.
- imem_data  in  INST_W  read data.
- inst1  out  3  opcode bits [7:5] to the control decoder.
- inst2  out  1  opcode bit [4] to the control decoder.
- inst_opnd  out  4  operand field, bits [3:0].
- ext_byte  out  INST_W  extension byte (offset or target).
- nextctrl  in  2  decoder output: 00 none, 01 offset byte, 10 target byte, 11 illegal.
- jctrl, jrctrl, beqctrl  in  1 each  decoder flow-control outputs.
- br_taken  in  1  datapath compare result for beq.
- ra_value  in  PC_W  return-address register value for jr.
- inst_valid  out  1  instruction bundle valid to the datapath.
- inst_ready  in  1  datapath accepts the bundle.
- ret_addr  out  PC_W  address following the current instruction, used for jal link.
- illegal  out  1  one-cycle pulse when nextctrl=11 is sampled.

Function
REQ-004 SHALL implement the FSM states FETCH, WAIT_OP, DECODE, FETCH_EXT, WAIT_EXT and ISSUE.
REQ-005 In FETCH: SHALL drive imem_req=1 with imem_addr=pc for exactly one cycle, then enter WAIT_OP.
REQ-006 In WAIT_OP: on imem_ack, SHALL load the instruction register from imem_data, set pc=pc+1 and enter DECODE; otherwise it stays in WAIT_OP.
REQ-007 inst1, inst2 and inst_opnd SHALL come from the instruction register and stay stable from DECODE until the cycle after the ISSUE handshake.
REQ-008 In DECODE (exactly one cycle): SHALL sample nextctrl.
- 01 or 10 go to FETCH_EXT.
- 00 goes to ISSUE.
- 11 goes to ISSUE, pulses illegal, and treats the instruction as nextctrl=00.
REQ-009 In FETCH_EXT: SHALL perform a one-cycle imem_req at pc, then enter WAIT_EXT; on imem_ack it SHALL load ext_byte, set pc=pc+1 and enter ISSUE.
REQ-010 ext_byte SHALL be zero for instructions that have no extension byte.
REQ-011 ret_addr SHALL equal pc as it stands on entry to ISSUE.
REQ-012 In ISSUE: inst_valid=1; it SHALL hold until inst_valid&&inst_ready, and the bundle SHALL NOT change while waiting.
REQ-013 On the ISSUE handshake, SHALL update pc using the decoder controls sampled that cycle, in this priority:
- jrctrl=1 gives ra_value.
- jctrl=1 and latched nextctrl=10 gives ext_byte.
- beqctrl=1 and br_taken=1 gives pc plus the sign-extended inst_opnd.
- otherwise pc is unchanged.
The FSM then enters FETCH.
REQ-014 PC arithmetic SHALL be modulo 2^PC_W; wrap from 8'hFF to 8'h00 is legal and silent.
REQ-015 Minimum latency from FETCH to inst_valid SHALL be 3 cycles for single-byte instructions and 5 cycles for two-byte instructions, with imem_ack on the cycle after imem_req.
REQ-016 imem_ack outside WAIT_OP and WAIT_EXT SHALL be ignored.
REQ-017 At most one outstanding memory request SHALL exist at any time.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL set:
- pc=0 and state=FETCH;
- instruction register=0 and ext_byte=0;
- imem_req=0, inst_valid=0, illegal=0 and ret_addr=0.
REQ-019 Reset asserted mid-transaction SHALL abandon it: imem_req deasserts in the following cycle, and an imem_ack arriving after reset SHALL be ignored.
REQ-020 The first fetch after reset SHALL issue at address 0 in the first cycle after rst deasserts.

Structure
REQ-021 Package fetch_pkg SHALL hold the following shared items:
- the FSM state enum;
- the nextctrl encodings (NC_NONE, NC_OFFSET, NC_TARGET, NC_ILLEGAL);
- the opcode field bit positions;
- PC_W and INST_W defaults.
REQ-022 The combinational next-PC selection SHALL be a single sub-module, pc_next_sel, which takes pc, ra_value, ext_byte, inst_opnd and the controls and returns the new pc.

Verification
REQ-023 Single-byte op: rst released with imem returning 8'h20 (add) at addr 0 and nextctrl=00.
- Required: inst1=3'b001, inst2=0 and inst_valid on cycle 3.
- Required: the next fetch is at addr 1.
REQ-024 lw with ext: 8'h80 at 0 and 8'h05 at 1, with nextctrl=01.
- Required: ext_byte=8'h05 and ret_addr=2.
- Required: the next fetch is at addr 2.
REQ-025 jal: opcode 1110 at 8'h10 and target 8'h40 at 8'h11, with jctrl=1 and nextctrl=10.
- Required: ret_addr=8'h12.
- Required: the next fetch is at 8'h40.
REQ-026 beq with opnd=4'hE, beqctrl=1 and br_taken=1 at pc 8'h01.
- Required: the next fetch is at 8'h00.
- Repeat with br_taken=0: the next fetch is at 8'h02.
REQ-027 Backpressure and wrap: inst_ready held low 4 cycles with the bundle stable, fetching at 8'hFF.
- Required: the next fetch is at 8'h00.
- Required: rst asserted during WAIT_EXT leads to a fetch at addr 0 after release.
